alu_8bit: RTL and testbench



---
 rtl/alu_8bit_pkg.sv | 21 ++
 rtl/alu_8bit_core.sv | 53 +++++
 rtl/alu_8bit.sv | 54 +++++
 tb/tb_alu_8bit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_8bit_pkg.sv
`default_nettype none
// ============================================================================
// alu_8bit_pkg : opcode encodings and datapath widths for the 8-bit ALU
// Revision     : 1.0
// ============================================================================
package alu_8bit_pkg;

   localparam int DATA_W = 8;
   localparam int RES_W  = 16;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

endpackage : alu_8bit_pkg
`default_nettype wire

// File: rtl/alu_8bit_core.sv
`default_nettype none
// ============================================================================
// alu_8bit_core : combinational opcode decode, (op, A, B) -> (result, carry)
// Revision      : 1.0
// ============================================================================
module alu_8bit_core
   import alu_8bit_pkg::*;
(
   input  logic [2:0]        operation_i,
   input  logic [DATA_W-1:0] operand_a_i,
   input  logic [DATA_W-1:0] operand_b_i,
   output logic [RES_W-1:0]  next_result_o,
   output logic              next_carry_o
);

   localparam int PAD_W = RES_W - DATA_W;

   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [RES_W-1:0]  w_prod;

   assign w_sum  = {1'b0, operand_a_i} + {1'b0, operand_b_i};
   // The 9th bit of the widened difference is the borrow (set iff A < B).
   assign w_diff = {1'b0, operand_a_i} - {1'b0, operand_b_i};
   assign w_prod = {{PAD_W{1'b0}}, operand_a_i} * {{PAD_W{1'b0}}, operand_b_i};

   always_comb begin
      next_result_o = '0;
      next_carry_o  = 1'b0;
      case (operation_i)
         OP_ADD: begin
            next_result_o = {{(PAD_W-1){1'b0}}, w_sum};
            next_carry_o  = w_sum[DATA_W];
         end
         OP_SUB: begin
            next_result_o = {{PAD_W{1'b0}}, w_diff[DATA_W-1:0]};
            next_carry_o  = w_diff[DATA_W];
         end
         OP_MUL:  next_result_o = w_prod;
         OP_AND:  next_result_o = {{PAD_W{1'b0}}, operand_a_i & operand_b_i};
         OP_OR:   next_result_o = {{PAD_W{1'b0}}, operand_a_i | operand_b_i};
         OP_NAND: next_result_o = {{PAD_W{1'b0}}, ~(operand_a_i & operand_b_i)};
         OP_NOR:  next_result_o = {{PAD_W{1'b0}}, ~(operand_a_i | operand_b_i)};
         OP_XOR:  next_result_o = {{PAD_W{1'b0}}, operand_a_i ^ operand_b_i};
         default: begin
            next_result_o = '0;
            next_carry_o  = 1'b0;
         end
      endcase
   end

endmodule : alu_8bit_core
`default_nettype wire

// File: rtl/alu_8bit.sv
`default_nettype none
// ============================================================================
// alu_8bit : registered 8-bit ALU, 1-cycle latency, 16-bit result + flags
// Revision : 1.0
// ============================================================================
module alu_8bit
   import alu_8bit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        operation,
   input  logic [DATA_W-1:0] operand_A,
   input  logic [DATA_W-1:0] operand_B,
   output logic [RES_W-1:0]  result,
   output logic              carry_flag,
   output logic              zero_flag
);

   logic [RES_W-1:0] result_d;
   logic             carry_d;
   logic             zero_d;
   logic [RES_W-1:0] result_q;
   logic             carry_q;
   logic             zero_q;

   alu_8bit_core u_core (
      .operation_i   (operation),
      .operand_a_i   (operand_A),
      .operand_b_i   (operand_B),
      .next_result_o (result_d),
      .next_carry_o  (carry_d)
   );

   // Zero detect spans the full 16-bit result, not just the low byte.
   assign zero_d = (result_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign result     = result_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;

endmodule : alu_8bit
`default_nettype wire

// File: tb/tb_alu_8bit.sv
`default_nettype none
// ============================================================================
// tb_alu_8bit : directed scoreboard bench for alu_8bit
// Revision    : 1.0
// ============================================================================
module tb_alu_8bit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  operation;
   logic [7:0]  operand_A;
   logic [7:0]  operand_B;
   logic [15:0] result;
   logic        carry_flag;
   logic        zero_flag;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [15:0] res;
      logic        c;
      logic        z;
   } exp_t;

   exp_t sb[$];

   alu_8bit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .operation  (operation),
      .operand_A  (operand_A),
      .operand_B  (operand_B),
      .result     (result),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [15:0] r, input logic c, input logic z);
      checks++;
      assert (result === r) else begin
         failures++;
         $error("FAIL %s result observed=%h expected=%h", tag, result, r);
      end
      checks++;
      assert (carry_flag === c) else begin
         failures++;
         $error("FAIL %s carry observed=%b expected=%b", tag, carry_flag, c);
      end
      checks++;
      assert (zero_flag === z) else begin
         failures++;
         $error("FAIL %s zero observed=%b expected=%b", tag, zero_flag, z);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input string tag, input logic [15:0] r, input logic c, input logic z);
      exp_t e;
      @(negedge clk);
      operation = op;
      operand_A = a;
      operand_B = b;
      e.tag = tag; e.res = r; e.c = c; e.z = z;
      sb.push_back(e);
   endtask

   task automatic capture();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(e.tag, e.res, e.c, e.z);
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input string tag, input logic [15:0] r, input logic c, input logic z);
      drive(op, a, b, tag, r, c, z);
      capture();
   endtask

   initial begin
      rst_n     = 1'b1;
      operation = 3'b000;
      operand_A = 8'h00;
      operand_B = 8'h00;
      #3 rst_n  = 1'b0;
      #1 cmp("reset_initial", 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operations with A=DA, B=27
      step(3'b000, 8'hDA, 8'h27, "add",    16'h0101, 1'b1, 1'b0);
      step(3'b001, 8'hDA, 8'h27, "sub",    16'h00B3, 1'b0, 1'b0);
      step(3'b001, 8'h05, 8'h07, "sub_bw", 16'h00FE, 1'b1, 1'b0);
      step(3'b010, 8'hDA, 8'h27, "mul",    16'h2136, 1'b0, 1'b0);
      step(3'b010, 8'hFF, 8'hFF, "mul_ff", 16'hFE01, 1'b0, 1'b0);
      step(3'b010, 8'h00, 8'h27, "mul_0",  16'h0000, 1'b0, 1'b1);
      step(3'b011, 8'hDA, 8'h27, "and",    16'h0002, 1'b0, 1'b0);
      step(3'b100, 8'hDA, 8'h27, "or",     16'h00FF, 1'b0, 1'b0);
      step(3'b101, 8'hDA, 8'h27, "nand",   16'h00FD, 1'b0, 1'b0);
      step(3'b110, 8'hDA, 8'h27, "nor",    16'h0000, 1'b0, 1'b1);
      step(3'b111, 8'hDA, 8'h27, "xor",    16'h00FD, 1'b0, 1'b0);
      step(3'b000, 8'hFF, 8'h01, "add_z16", 16'h0100, 1'b1, 1'b0);

      // Back-to-back: a new opcode every cycle, carry must not leak
      step(3'b000, 8'hDA, 8'h27, "b2b_add",  16'h0101, 1'b1, 1'b0);
      step(3'b001, 8'hDA, 8'h27, "b2b_sub",  16'h00B3, 1'b0, 1'b0);
      step(3'b010, 8'hDA, 8'h27, "b2b_mul",  16'h2136, 1'b0, 1'b0);
      step(3'b011, 8'hDA, 8'h27, "b2b_and",  16'h0002, 1'b0, 1'b0);
      step(3'b100, 8'hDA, 8'h27, "b2b_or",   16'h00FF, 1'b0, 1'b0);
      step(3'b101, 8'hDA, 8'h27, "b2b_nand", 16'h00FD, 1'b0, 1'b0);
      step(3'b110, 8'hDA, 8'h27, "b2b_nor",  16'h0000, 1'b0, 1'b1);
      step(3'b111, 8'hDA, 8'h27, "b2b_xor",  16'h00FD, 1'b0, 1'b0);

      // Mid-cycle asynchronous reset after a nonzero result
      step(3'b000, 8'hDA, 8'h27, "pre_rst", 16'h0101, 1'b1, 1'b0);
      @(negedge clk);
      operation = 3'b010;
      operand_A = 8'hFF;
      operand_B = 8'hFF;
      #2 rst_n = 1'b0;
      #1 cmp("reset_async", 16'h0000, 1'b0, 1'b1);
      @(posedge clk);
      #1 cmp("reset_hold", 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b000, 8'hDA, 8'h27, "post_rst", 16'h0101, 1'b1, 1'b0);

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_8bit
`default_nettype wire
